// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter sharing one memory bus between the fetch and memory stages.
// Data side wins ties, bounded by MAX_SKIP consecutive wins while fetch is waiting.
module mem_bus_arbiter #(
  parameter int unsigned MAX_SKIP = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_ok,
  output logic [63:0] i_rdata,

  input  logic        d_valid,
  input  logic        d_write,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_ok,
  output logic [63:0] d_rdata,

  output logic        bus_valid,
  output logic        bus_write,
  output logic [63:0] bus_addr,
  output logic [2:0]  bus_size,
  output logic [7:0]  bus_strobe,
  output logic [63:0] bus_wdata,
  input  logic        bus_ok,
  input  logic [63:0] bus_rdata
);

  localparam logic [2:0] MSIZE4   = 3'd2;
  localparam logic [2:0] SKIP_LIM = 3'(MAX_SKIP);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  state_t      r_state;
  owner_t      r_owner;
  logic [2:0]  r_skip;
  logic        r_bus_write;
  logic [63:0] r_bus_addr;
  logic [2:0]  r_bus_size;
  logic [7:0]  r_bus_strobe;
  logic [63:0] r_bus_wdata;

  state_t      w_state_nxt;
  owner_t      w_owner_nxt;
  logic [2:0]  w_skip_nxt;
  logic        w_load;
  logic        w_pick_data;
  logic        w_i_ok;
  logic        w_d_ok;

  logic        w_nxt_write;
  logic [63:0] w_nxt_addr;
  logic [2:0]  w_nxt_size;
  logic [7:0]  w_nxt_strobe;
  logic [63:0] w_nxt_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_owner      <= OWN_FETCH;
      r_skip       <= 3'd0;
      r_bus_write  <= 1'b0;
      r_bus_addr   <= 64'd0;
      r_bus_size   <= 3'd0;
      r_bus_strobe <= 8'd0;
      r_bus_wdata  <= 64'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_skip  <= w_skip_nxt;
      if (w_load) begin
        r_bus_write  <= w_nxt_write;
        r_bus_addr   <= w_nxt_addr;
        r_bus_size   <= w_nxt_size;
        r_bus_strobe <= w_nxt_strobe;
        r_bus_wdata  <= w_nxt_wdata;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_skip_nxt  = r_skip;
    w_load      = 1'b0;
    w_pick_data = 1'b0;
    w_i_ok      = 1'b0;
    w_d_ok      = 1'b0;
    case (r_state)
      IDLE: begin
        // The skip counter never exceeds the limit, so "<" is the same as "!=".
        w_pick_data = d_valid && (!i_valid || (r_skip < SKIP_LIM));
        if (i_valid || d_valid) begin
          w_load      = 1'b1;
          w_state_nxt = BUSY;
          w_owner_nxt = w_pick_data ? OWN_DATA : OWN_FETCH;
        end
        if (i_valid && w_pick_data) begin
          w_skip_nxt = r_skip + 3'd1;
        end else begin
          w_skip_nxt = 3'd0;
        end
      end
      BUSY: begin
        if (bus_ok) begin
          w_state_nxt = IDLE;
          w_i_ok      = (r_owner == OWN_FETCH);
          w_d_ok      = (r_owner == OWN_DATA);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    if (w_pick_data) begin
      w_nxt_write  = d_write;
      w_nxt_addr   = d_addr;
      w_nxt_size   = d_size;
      w_nxt_strobe = d_strobe;
      w_nxt_wdata  = d_wdata;
    end else begin
      w_nxt_write  = 1'b0;
      w_nxt_addr   = i_addr;
      w_nxt_size   = MSIZE4;
      w_nxt_strobe = 8'd0;
      w_nxt_wdata  = 64'd0;
    end
  end

  assign bus_valid  = (r_state == BUSY);
  assign bus_write  = r_bus_write;
  assign bus_addr   = r_bus_addr;
  assign bus_size   = r_bus_size;
  assign bus_strobe = r_bus_strobe;
  assign bus_wdata  = r_bus_wdata;

  assign i_ok    = w_i_ok;
  assign d_ok    = w_d_ok;
  assign i_rdata = bus_rdata;
  assign d_rdata = bus_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: per-requester expected queues popped on each ok pulse,
// a latency-configurable bus responder, and directed plus random request traffic.
module tb_mem_bus_arbiter;

  localparam int FW = 140;
  localparam logic [2:0] MSIZE4 = 3'd2;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic [63:0] i_addr;
  logic        i_ok;
  logic [63:0] i_rdata;
  logic        d_valid;
  logic        d_write;
  logic [63:0] d_addr;
  logic [2:0]  d_size;
  logic [7:0]  d_strobe;
  logic [63:0] d_wdata;
  logic        d_ok;
  logic [63:0] d_rdata;
  logic        bus_valid;
  logic        bus_write;
  logic [63:0] bus_addr;
  logic [2:0]  bus_size;
  logic [7:0]  bus_strobe;
  logic [63:0] bus_wdata;
  logic        bus_ok;
  logic [63:0] bus_rdata;

  logic [FW-1:0] fields;
  assign fields = {bus_write, bus_addr, bus_size, bus_strobe, bus_wdata};

  mem_bus_arbiter #(.MAX_SKIP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_addr    (i_addr),
    .i_ok      (i_ok),
    .i_rdata   (i_rdata),
    .d_valid   (d_valid),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_size    (d_size),
    .d_strobe  (d_strobe),
    .d_wdata   (d_wdata),
    .d_ok      (d_ok),
    .d_rdata   (d_rdata),
    .bus_valid (bus_valid),
    .bus_write (bus_write),
    .bus_addr  (bus_addr),
    .bus_size  (bus_size),
    .bus_strobe(bus_strobe),
    .bus_wdata (bus_wdata),
    .bus_ok    (bus_ok),
    .bus_rdata (bus_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_of(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 64'h13;
    return a ^ 64'h5A5A_0F0F_C3C3_9696;
  endfunction

  logic [63:0]   iq[$];
  logic [FW-1:0] dq[$];
  bit            glog[$];
  int            n_iok = 0;
  int            n_dok = 0;

  int resp_lat = 3;
  bit rand_lat = 0;
  bit poke     = 0;

  // Bus responder: answers each bus transaction after a chosen number of BUSY cycles.
  initial begin
    int cnt;
    int cur_lat;
    cnt = 0;
    cur_lat = 1;
    bus_ok = 1'b0;
    bus_rdata = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      if (poke) begin
        bus_ok = 1'b1;
        bus_rdata = {$urandom, $urandom};
      end else if (bus_valid && !bus_ok) begin
        if (cnt == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : resp_lat;
        cnt++;
        if (cnt >= cur_lat) begin
          bus_ok = 1'b1;
          bus_rdata = mem_of(bus_addr);
        end else begin
          bus_rdata = {$urandom, $urandom};
        end
      end else begin
        bus_ok = 1'b0;
        cnt = 0;
        bus_rdata = {$urandom, $urandom};
      end
    end
  end

  // Monitor: protocol invariants every cycle, scoreboard pops on each ok pulse.
  initial begin
    logic          prev_valid;
    logic [FW-1:0] snap;
    bit            expect_bubble;
    logic [63:0]   a;
    logic [FW-1:0] e;
    prev_valid = 1'b0;
    snap = '0;
    expect_bubble = 1'b0;
    forever begin
      @(negedge clk);
      chk("i_rdata_pass", FW'(i_rdata), FW'(bus_rdata));
      chk("d_rdata_pass", FW'(d_rdata), FW'(bus_rdata));
      chk("ok_excl", FW'(i_ok & d_ok), '0);
      chk("ok_in_busy", FW'((i_ok | d_ok) & ~bus_valid), '0);
      if (expect_bubble) begin
        chk("bubble", FW'(bus_valid), '0);
        expect_bubble = 1'b0;
      end
      if (prev_valid && bus_valid) chk("bus_stable", fields, snap);
      prev_valid = bus_valid;
      snap = fields;
      if (i_ok) begin
        expect_bubble = 1'b1;
        n_iok++;
        glog.push_back(1'b1);
        if (iq.size() == 0) begin
          chk("i_ok_unexpected", FW'(i_ok), '0);
        end else begin
          a = iq.pop_front();
          chk("i_bus_fields", fields, {1'b0, a, MSIZE4, 8'h00, 64'h0});
          chk("i_rdata", FW'(i_rdata), FW'(mem_of(a)));
        end
      end
      if (d_ok) begin
        expect_bubble = 1'b1;
        n_dok++;
        glog.push_back(1'b0);
        if (dq.size() == 0) begin
          chk("d_ok_unexpected", FW'(d_ok), '0);
        end else begin
          e = dq.pop_front();
          chk("d_bus_fields", fields, e);
          if (!e[FW-1]) chk("d_rdata", FW'(d_rdata), FW'(mem_of(e[138:75])));
        end
      end
    end
  end

  task automatic fetch_req(input logic [63:0] a, input int gap);
    bit seen = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    i_valid = 1'b1;
    i_addr  = a;
    iq.push_back(a);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (i_ok) begin
        seen = 1'b1;
        break;
      end
    end
    chk("fetch_done", FW'(seen), FW'(1));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic data_req(input logic w, input logic [63:0] a, input logic [2:0] sz,
                          input logic [7:0] st, input logic [63:0] wd, input int gap);
    bit seen = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    d_valid  = 1'b1;
    d_write  = w;
    d_addr   = a;
    d_size   = sz;
    d_strobe = st;
    d_wdata  = wd;
    dq.push_back({w, a, sz, st, wd});
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (d_ok) begin
        seen = 1'b1;
        break;
      end
    end
    chk("data_done", FW'(seen), FW'(1));
    @(posedge clk);
    #1;
    d_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int waits;
    int i0;
    int d0;
    bit exp_cont[7];
    exp_cont = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b0;
    i_valid = 1'b0;
    i_addr = 64'd0;
    d_valid = 1'b0;
    d_write = 1'b0;
    d_addr = 64'd0;
    d_size = 3'd0;
    d_strobe = 8'd0;
    d_wdata = 64'd0;
    #1;
    chk("rst_fields", fields, '0);
    chk("rst_valid", FW'(bus_valid), '0);
    chk("rst_ok", FW'({i_ok, d_ok}), '0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single fetch with a three-cycle bus latency.
    resp_lat = 3;
    i_valid = 1'b1;
    i_addr = 64'h0000_0000_8000_0000;
    iq.push_back(i_addr);
    @(negedge clk);
    chk("t0_bus_valid", FW'(bus_valid), '0);
    @(negedge clk);
    chk("t1_bus_valid", FW'(bus_valid), FW'(1));
    chk("t1_bus_write", FW'(bus_write), '0);
    seen = 1'b0;
    waits = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (i_ok) begin
        seen = 1'b1;
        waits = k;
        break;
      end
    end
    chk("f_seen", FW'(seen), FW'(1));
    chk("f_latency", FW'(waits), FW'(2));
    chk("f_rdata13", FW'(i_rdata), FW'(64'h13));
    chk("f_no_dok", FW'(d_ok), '0);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Store and load through the data port.
    data_req(1'b1, 64'h0000_0000_8000_1008, 3'd3, 8'hFF, 64'h0000_0000_DEAD_BEEF, 0);
    data_req(1'b0, 64'h0000_0000_8000_2004, 3'd2, 8'h0F, 64'h0, 1);
    repeat (2) @(posedge clk);
    #1;

    // bus_ok while idle must be ignored.
    poke = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_bus_ok", FW'({bus_valid, i_ok, d_ok}), '0);
    end
    poke = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Requester drops valid mid-transaction; the ok pulse must still come.
    resp_lat = 4;
    d_valid = 1'b1;
    d_write = 1'b0;
    d_addr = 64'h0000_0000_2000_0100;
    d_size = 3'd3;
    d_strobe = 8'h00;
    d_wdata = 64'h0;
    dq.push_back({1'b0, d_addr, 3'd3, 8'h00, 64'h0});
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_ok) begin
        seen = 1'b1;
        break;
      end
    end
    chk("deassert_ok", FW'(seen), FW'(1));
    repeat (3) @(posedge clk);
    #1;

    // Contention: grant order D,D,D,D,F,D,D with MAX_SKIP=4.
    resp_lat = 2;
    glog.delete();
    fork
      fetch_req(64'h0000_0000_0000_5000, 0);
      begin
        for (int k = 0; k < 6; k++)
          data_req(1'b1, 64'h6000 + 64'(8 * k), 3'd3, 8'hFF, {$urandom, $urandom}, 0);
      end
    join
    chk("cont_count", FW'(glog.size()), FW'(7));
    for (int k = 0; k < 7 && k < glog.size(); k++)
      chk($sformatf("cont_grant%0d", k), FW'(glog[k]), FW'(exp_cont[k]));
    repeat (3) @(posedge clk);
    #1;

    // Data arrives during fetch's bus_ok cycle: served only after an idle bubble.
    resp_lat = 3;
    glog.delete();
    fork
      fetch_req(64'h0000_0000_0000_3000, 0);
      data_req(1'b0, 64'h0000_0000_0000_4000, 3'd2, 8'h0F, 64'h0, 3);
    join
    chk("late_count", FW'(glog.size()), FW'(2));
    if (glog.size() == 2) begin
      chk("late_first_f", FW'(glog[0]), FW'(1));
      chk("late_second_d", FW'(glog[1]), '0);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset two cycles into BUSY abandons the transaction.
    resp_lat = 10;
    i_valid = 1'b1;
    i_addr = 64'h0000_0000_1000_0040;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("busy_pre_rst", FW'(bus_valid), FW'(1));
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", FW'(bus_valid), '0);
    chk("async_rst_fields", fields, '0);
    chk("async_rst_ok", FW'({i_ok, d_ok}), '0);
    @(posedge clk);
    #1;
    chk("held_rst_valid", FW'(bus_valid), '0);
    resp_lat = 3;
    iq.push_back(i_addr);
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (i_ok) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_recover", FW'(seen), FW'(1));
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Random traffic with held-stable requesters and random bus latency.
    rand_lat = 1'b1;
    i0 = n_iok;
    d0 = n_dok;
    fork
      begin
        for (int k = 0; k < 15; k++)
          fetch_req({32'h0, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC, int'($urandom_range(0, 3)));
      end
      begin
        for (int j = 0; j < 15; j++)
          data_req(1'($urandom_range(0, 1)), {$urandom, $urandom}, 3'($urandom_range(0, 3)),
                   8'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)));
      end
    join
    chk("rand_iok", FW'(n_iok - i0), FW'(15));
    chk("rand_dok", FW'(n_dok - d0), FW'(15));
    repeat (4) @(posedge clk);
    #1;
    chk("iq_empty", FW'(iq.size()), '0);
    chk("dq_empty", FW'(dq.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have exactly one parameter: MAX_SKIP, default 4, the number of consecutive data-side wins allowed while fetch waits (range 1..7).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low, with ports named as follows.
REQ-003 clk  in  1  clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 i_valid, i_addr  in  1, 64  fetch-stage read request and its byte address.
REQ-006 i_ok, i_rdata  out  1, 64  fetch completion pulse and read data.
REQ-007 d_valid, d_write, d_addr, d_size, d_strobe, d_wdata  in  1, 1, 64, 3, 8, 64  memory-stage request; d_size uses msize encoding.
REQ-008 d_ok, d_rdata  out  1, 64  memory-stage completion pulse and read data.
REQ-009 bus_valid, bus_write, bus_addr, bus_size, bus_strobe, bus_wdata  out  1, 1, 64, 3, 8, 64  shared memory-bus request.
REQ-010 bus_ok, bus_rdata  in  1, 64  bus completion pulse and read data.

Function
REQ-011 The block SHALL implement two states: IDLE and BUSY, plus a 1-bit owner register (FETCH/DATA) and a 3-bit skip counter.
REQ-012 Requester protocol: valid and all fields are held stable from assertion until the cycle the matching ok is high.
REQ-013 In IDLE, arbitration SHALL sample i_valid/d_valid every cycle; with neither high, state stays IDLE.
REQ-014 Only d_valid high: grant DATA; only i_valid high: grant FETCH.
REQ-015 Both high: grant DATA unless skip counter equals MAX_SKIP, in which case grant FETCH.
REQ-016 Skip counter: +1 when both valid and DATA granted; cleared to 0 when FETCH granted or when i_valid is low in IDLE; never exceeds MAX_SKIP.
REQ-017 On grant, the winner's fields SHALL be registered into bus_* (fetch: bus_write=0, bus_size=MSIZE4, bus_strobe=0, bus_wdata=0), owner set, state BUSY on the next edge.
REQ-018 bus_valid SHALL be 1 exactly while in BUSY; bus_* fields SHALL be constant throughout BUSY.
REQ-019 In BUSY with bus_ok=1: i_ok (owner FETCH) or d_ok (owner DATA) SHALL equal 1 combinationally in that same cycle; state returns to IDLE on the next edge.
REQ-020 i_ok and d_ok SHALL never be high simultaneously and SHALL be 0 outside BUSY.
REQ-021 i_rdata and d_rdata SHALL both equal bus_rdata combinationally at all times.
REQ-022 Latency: request sampled in IDLE at cycle t -> bus_valid at t+1; bus_ok at t+k -> ok at t+k; next arbitration at t+k+1 (one IDLE bubble minimum between transactions).
REQ-023 bus_ok while in IDLE SHALL be ignored.
REQ-024 Requester deasserting valid during BUSY SHALL not abort the bus transaction; the ok pulse is still issued.
REQ-025 A requester asserting valid during BUSY SHALL be considered only at the next IDLE cycle.

Reset
REQ-026 reset low SHALL immediately force state IDLE, owner FETCH, skip counter 0, bus_valid 0, all bus_* fields 0, i_ok 0, d_ok 0, regardless of clock.
REQ-027 Reset mid-transaction SHALL abandon it without an ok pulse; after release, arbitration restarts in IDLE with the then-current valids.

Verification
REQ-028 Single fetch: i_valid=1, i_addr=0x8000_0000, bus_ok after 3 cycles, bus_rdata=0x13 -> bus_valid 1 from t+1, bus_write 0, i_ok 1 for one cycle with i_rdata 0x13, d_ok stays 0.
REQ-029 Store: d_valid=1, d_write=1, d_addr=0x80001008, d_size=MSIZE8, d_strobe=0xFF, d_wdata=0xDEADBEEF -> bus_* match exactly; d_ok pulses on bus_ok.
REQ-030 Contention, MAX_SKIP=4: both valid continuously, data re-requesting each IDLE -> grant order D,D,D,D,F,D..., skip counter 0,1,2,3,4,0.
REQ-031 Simultaneous bus_ok and new d_valid in BUSY -> d_ok pulses, next cycle IDLE, new grant cycle after; no back-to-back bus_valid without one low cycle.
REQ-032 reset low two cycles into BUSY -> bus_valid 0 asynchronously, no ok pulse; after release with i_valid=1, fetch granted normally.
REQ-033 Random stimulus with held-stable protocol -> every request receives exactly one ok; i_ok&d_ok never 1; bus fields stable while bus_valid.
